// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU core and its iterative multiply/divide unit.
package alu_pkg;

   localparam int ALU_WIDTH = 8;

   typedef enum logic [3:0] {
      ADD = 4'd0, SUB = 4'd1, MUL = 4'd2, DIV = 4'd3,
      MOD = 4'd4, AND = 4'd5, OR  = 4'd6, XOR = 4'd7,
      NOT = 4'd8, SHL = 4'd9, SHR = 4'd10, ROL = 4'd11,
      ROR = 4'd12, CMP = 4'd13, INC = 4'd14, DEC = 4'd15
   } opcode_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MUL_RUN = 2'd1,
      DIV_RUN = 2'd2
   } state_e;

   function automatic logic is_multi(opcode_e op);
      return (op == MUL) || (op == DIV) || (op == MOD);
   endfunction

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between an ALU requester (master) and the ALU core (slave).
interface alu_if #(parameter int WIDTH = alu_pkg::ALU_WIDTH);
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic [3:0]         s;
   logic               in_valid;
   logic               busy;
   logic [2*WIDTH-1:0] out;
   logic               out_valid;
   logic               div_err;

   modport master (output a, b, s, in_valid, input busy, out, out_valid, div_err);
   modport slave  (input a, b, s, in_valid, output busy, out, out_valid, div_err);
endinterface

// File: rtl/alu_iter_unit.sv
// Iterative datapath: shift-add multiply and restoring divide, one bit per clock.
module alu_iter_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int ITER  = WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  opcode_e            op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] result,
   output logic               err
);
   localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

   opcode_e            op_q;
   logic               running;
   logic               err_q;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   dvsr;
   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     diff;
   logic               ge;

   always_comb begin
      shifted = {rem, quo[WIDTH-1]};
      diff    = shifted - {1'b0, dvsr};
      ge      = shifted >= {1'b0, dvsr};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q    <= ADD;
         running <= 1'b0;
         done    <= 1'b0;
         err_q   <= 1'b0;
         cnt     <= '0;
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         rem     <= '0;
         quo     <= '0;
         dvsr    <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            op_q    <= op;
            running <= 1'b1;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, a};
            mplier  <= b;
            rem     <= '0;
            quo     <= a;
            dvsr    <= b;
            err_q   <= (op != MUL) && (b == '0);
         end else if (running) begin
            if (op_q == MUL) begin
               if (mplier[0]) acc <= acc + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
            end else begin
               rem <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
               quo <= {quo[WIDTH-2:0], ge};
            end
            if (cnt == CW'(ITER - 1)) begin
               running <= 1'b0;
               done    <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   // A zero divisor still runs the full schedule; only the reported value is forced.
   always_comb begin
      if (op_q == MUL)      result = acc;
      else if (err_q)       result = '1;
      else if (op_q == DIV) result = {{WIDTH{1'b0}}, quo};
      else                  result = {{WIDTH{1'b0}}, rem};
   end

   assign err = err_q;

endmodule

// File: rtl/alu_core.sv
// ALU core: single-cycle ops through a one-stage result pipe, MUL/DIV/MOD via alu_iter_unit.
//   state   | meaning
//   IDLE    | accepting operands (busy low unless a result is being retired)
//   MUL_RUN | shift-add multiply iterating
//   DIV_RUN | restoring divide iterating (DIV or MOD)
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int ITER  = WIDTH
) (
   input logic clk,
   input logic rst,
   alu_if.slave bus
);
   localparam int W2 = 2 * WIDTH;
   localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

   opcode_e          op;
   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             accept, multi, busy_int;
   logic             unit_done, unit_err;
   logic [W2-1:0]    unit_result, sc_result, sc_q, out_q;
   logic             sc_v_q, out_valid_q, div_err_q;
   logic [W2-1:0]    a_z, b_z;
   logic [2:0]       sh_amt;
   logic [WIDTH-1:0] rot_l, rot_r;

   assign op       = opcode_e'(bus.s);
   assign multi    = is_multi(op);
   // The unit's done pulse keeps busy up for the cycle in which its result is retired.
   assign busy_int = (state_q != IDLE) || unit_done;
   assign accept   = bus.in_valid && !busy_int;

   assign a_z    = {{WIDTH{1'b0}}, bus.a};
   assign b_z    = {{WIDTH{1'b0}}, bus.b};
   assign sh_amt = bus.b[2:0];
   assign rot_l  = (bus.a << sh_amt) | (bus.a >> (WIDTH - int'(sh_amt)));
   assign rot_r  = (bus.a >> sh_amt) | (bus.a << (WIDTH - int'(sh_amt)));

   always_comb begin
      sc_result = '0;
      case (op)
         ADD:     sc_result = a_z + b_z;
         SUB:     sc_result = a_z - b_z;
         AND:     sc_result = a_z & b_z;
         OR:      sc_result = a_z | b_z;
         XOR:     sc_result = a_z ^ b_z;
         NOT:     sc_result = {{WIDTH{1'b0}}, ~bus.a};
         SHL:     sc_result = {{WIDTH{1'b0}}, bus.a << sh_amt};
         SHR:     sc_result = {{WIDTH{1'b0}}, bus.a >> sh_amt};
         ROL:     sc_result = {{WIDTH{1'b0}}, rot_l};
         ROR:     sc_result = {{WIDTH{1'b0}}, rot_r};
         CMP:     sc_result = {{(W2-3){1'b0}}, bus.a > bus.b, bus.a == bus.b, bus.a < bus.b};
         INC:     sc_result = a_z + W2'(1);
         DEC:     sc_result = a_z - W2'(1);
         default: sc_result = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept && (op == MUL)) begin
               state_d = MUL_RUN;
               cnt_d   = '0;
            end else if (accept && multi) begin
               state_d = DIV_RUN;
               cnt_d   = '0;
            end
         end
         MUL_RUN, DIV_RUN: begin
            if (cnt_q == CW'(ITER - 1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   alu_iter_unit #(.WIDTH(WIDTH), .ITER(ITER)) u_iter (
      .clk    (clk),
      .rst    (rst),
      .start  (accept && multi),
      .op     (op),
      .a      (bus.a),
      .b      (bus.b),
      .done   (unit_done),
      .result (unit_result),
      .err    (unit_err)
   );

   // Single-cycle results are staged once so every result leaves from one register.
   always_ff @(posedge clk) begin
      if (rst) begin
         sc_q        <= '0;
         sc_v_q      <= 1'b0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         div_err_q   <= 1'b0;
      end else begin
         sc_v_q      <= accept && !multi;
         out_valid_q <= 1'b0;
         if (accept && !multi) sc_q <= sc_result;
         if (unit_done) begin
            out_q       <= unit_result;
            out_valid_q <= 1'b1;
            div_err_q   <= unit_err;
         end else if (sc_v_q) begin
            out_q       <= sc_q;
            out_valid_q <= 1'b1;
            div_err_q   <= 1'b0;
         end
      end
   end

   assign bus.busy      = busy_int;
   assign bus.out       = out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.div_err   = div_err_q;

endmodule
